// File: rtl/vga_timing_gen_if.sv
// vga_if: raster stream shared by the timing generator and every draw stage.
//   hcount/vcount - current pixel/line position (11 bits each)
//   hsync/vsync   - active-high sync strobes
//   hblnk/vblnk   - blanking strobes
//   rgb           - 12-bit colour for the current pixel
// Modports: out (stream source), in (stream sink).
interface vga_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: source of the vga_if raster stream. Generates hcount/vcount, sync and
// blanking strobes for a parameterisable mode (default 800x600@60, 40 MHz pixel clock),
// drives a base colour in the active area and pulses line_start/frame_start on raster wrap.
//   clk         - pixel clock
//   rst         - synchronous reset, active-high (overrides en)
//   en          - pixel enable; raster advances only when high
//   frame_start - one-cycle pulse when the raster enters (0,0)
//   line_start  - one-cycle pulse when the raster enters hcount=0
//   vga_out     - vga_if.out stream
// Optional build macro VGA_TEST_PATTERN_EN: active-area rgb shows 8 vertical colour bars
// instead of BASE_RGB.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic [11:0] BASE_RGB = 12'h000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic frame_start,
  output logic line_start,
  vga_if.out   vga_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 11-bit counters");
  end

  localparam logic [10:0] HTotM1   = 11'(H_TOTAL - 1);
  localparam logic [10:0] VTotM1   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HAct     = 11'(H_ACTIVE);
  localparam logic [10:0] VAct     = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncBeg = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic [11:0] rgb_q, rgb_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [11:0] active_rgb;

  // Next raster position.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (hcount_q == HTotM1) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VTotM1) ? '0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / 8;

  logic [2:0] bar_idx;

  // Bar index from a compare chain on the next hcount; the smallest matching bar wins.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (hcount_d < 11'((i + 1) * BarW)) begin
        bar_idx = 3'(i);
      end
    end
  end

  always_comb begin
    case (bar_idx)
      3'd0:    active_rgb = 12'hFFF;
      3'd1:    active_rgb = 12'hFF0;
      3'd2:    active_rgb = 12'h0FF;
      3'd3:    active_rgb = 12'h0F0;
      3'd4:    active_rgb = 12'hF0F;
      3'd5:    active_rgb = 12'hF00;
      3'd6:    active_rgb = 12'h00F;
      default: active_rgb = 12'h000;
    endcase
  end
`else
  assign active_rgb = BASE_RGB;
`endif

  // Strobes and colour follow the next count so they line up with it once registered.
  // With en low every field holds, including the all-zero colour left by reset.
  always_comb begin
    hsync_d = hsync_q;
    hblnk_d = hblnk_q;
    vsync_d = vsync_q;
    vblnk_d = vblnk_q;
    rgb_d   = rgb_q;
    if (en) begin
      hblnk_d = (hcount_d >= HAct);
      hsync_d = (hcount_d >= HSyncBeg) && (hcount_d < HSyncEnd);
      vblnk_d = (vcount_d >= VAct);
      vsync_d = (vcount_d >= VSyncBeg) && (vcount_d < VSyncEnd);
      rgb_d   = (hblnk_d || vblnk_d) ? 12'h000 : active_rgb;
    end
  end

  // An enabled step only lands on hcount=0 through a wrap.
  always_comb begin
    line_start_d  = en && (hcount_d == '0);
    frame_start_d = line_start_d && (vcount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      rgb_q         <= rgb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the vga_if stream. Every draw stage (background, sprite, text overlays) consumes this stream.
- Generates the hcount/vcount raster counters and the hsync, vsync, hblnk and vblnk strobes for a parameterisable mode. The default mode is 800x600@60, 40 MHz pixel clock.
- Drives rgb to a known base colour, which downstream stages overwrite.
- Provides frame_start and line_start pulses so game logic can update sprite positions and animation counters only between frames.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- BASE_RGB, 12'h000, rgb driven in the active area when the test pattern is disabled

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- en  in  1  pixel enable; counters and strobes advance only when high
- frame_start  out  1  one-cycle pulse when the raster enters (hcount=0, vcount=0)
- line_start  out  1  one-cycle pulse when the raster enters hcount=0 (any line)
- vga_out  vga_if.out  -  hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0] (38 bits)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628). Both must fit in 11 bits; elaborate-time error otherwise.
- Reset (rst=1 at a clk edge): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, rgb=0, frame_start=0, line_start=0. Reset overrides en.
- All outputs are registered, and every output in a given cycle is consistent with the hcount/vcount shown in that same cycle. Strobes are computed from the next-count value, so no strobe lags its count.
- Counter step, on a clk edge with rst=0 and en=1:
  - hcount := (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - When hcount wraps, vcount := (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - Otherwise vcount holds.
- With en=0: all vga_out fields hold their value; frame_start and line_start are forced to 0.
- hblnk = 1 for hcount >= H_ACTIVE (800..1055).
- hsync = 1 for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967). Active-high.
- vblnk = 1 for vcount >= V_ACTIVE (600..627).
- vsync = 1 for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604). Active-high.
- rgb = 12'h000 whenever hblnk or vblnk is 1. Otherwise rgb = BASE_RGB, or the pattern (see Optional Feature).
- line_start = 1 for exactly the one cycle in which hcount transitions to 0 via an en=1 step.
- frame_start = 1 when that transition also takes vcount to 0.
- Boundaries:
  - Leaving reset does not pulse frame_start/line_start; the first pulse is at the first natural wrap.
  - en toggling mid-line resumes exactly where the raster stopped.
  - rst asserted mid-frame returns everything to the reset values at the next edge.
  - Full sequence: 1056*628 = 663168 enabled cycles per frame.
  - First enabled step after reset shows hcount=1, vcount=0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: active-area rgb is 8 vertical colour bars, each H_ACTIVE/8 pixels wide (100). Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Bar index = hcount / (H_ACTIVE/8), computed without a divider (compare chain). The bar lookup is registered with the same alignment as the other fields.
- Undefined: active-area rgb = BASE_RGB. No pattern logic is synthesised.
- Blanking forces 000 in both builds.

Test Plan:
- Reset held 5 cycles, then released with en=1 → all outputs 0 during reset; first edge after release gives hcount=1, vcount=0, all strobes 0, no pulses.
- Run one line from reset → hblnk rises at hcount=800; hsync high for hcount 840..967 (128 cycles); hcount 1055 wraps to 0 with vcount=1 and line_start=1 for 1 cycle.
- Run a full frame → vblnk high for vcount 600..627; vsync high exactly for vcount 601..604; frame_start pulses once after 663168 enabled cycles, with hcount=0 and vcount=0 in that cycle.
- Drive en low for 10 cycles at hcount=500, vcount=300 → all fields frozen at those values, no pulses; counting resumes at 501 when en returns high.
- Assert rst for 1 cycle at hcount=900, vcount=602 (hsync and vsync both high) → next cycle all outputs 0; the following cycle shows hcount=1.
- With VGA_TEST_PATTERN_EN, line 10 → rgb = FFF at hcount 0..99, FF0 at 100..199, ..., 000 at 700..799, and 000 during blanking. Without the macro, BASE_RGB=12'h0A5 appears at every active pixel.
